// File: rtl/reg_lock_tracker.sv
// Register lock / memory-count / fence tracker that gates issue arbitration.
// Locks are set on accept and released from NWB write-back ports; a fence blocks all issue.
module reg_lock_tracker #(
    parameter int unsigned NR        = 64,
    parameter int unsigned NWB       = 2,
    parameter int unsigned MEM_DEPTH = 4,
    localparam int unsigned RW       = $clog2(NR),
    localparam int unsigned CW       = $clog2(MEM_DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pl_valid_i,
    input  logic                blocking_i,
    input  logic [RW-1:0]       rd_i,
    input  logic [NR-1:0]       reg_req_i,
    input  logic                mem_op_i,
    input  logic                arb_gnt_i,
    input  logic [NWB-1:0]      wb_valid_i,
    input  logic [NWB*RW-1:0]   wb_rd_i,
    input  logic                mem_done_i,
    input  logic                blk_done_i,
    output logic                arb_req_o,
    output logic [NR-1:0]       locks_o,
    output logic [CW-1:0]       mem_cnt_o,
    output logic                mem_busy_o,
    output logic                blk_active_o
);

    logic [NR-1:0] r_locks;
    logic [CW-1:0] r_cnt;
    logic          r_blk;

    logic          w_full;
    logic          w_drained;
    logic          w_waw;
    logic          w_accept;
    logic          w_inc;
    logic [NR-1:0] w_locks_nxt;

    assign w_full    = (r_cnt == CW'(MEM_DEPTH));
    assign w_drained = ~|r_locks & (r_cnt == '0);
    assign w_waw     = (rd_i != '0) & r_locks[rd_i];

    assign arb_req_o = pl_valid_i & ~r_blk & ~|(reg_req_i & r_locks) & ~w_waw
                       & ~(mem_op_i & w_full) & ~(blocking_i & ~w_drained);

    assign w_accept  = arb_gnt_i & arb_req_o;
    assign w_inc     = w_accept & mem_op_i;

    // Clears first, then the accept set, so a same-index set wins.
    always_comb begin
        w_locks_nxt = r_locks;
        for (int p = 0; p < int'(NWB); p++) begin
            if (wb_valid_i[p]) begin
                w_locks_nxt[wb_rd_i[p*RW +: RW]] = 1'b0;
            end
        end
        if (w_accept) begin
            w_locks_nxt[rd_i] = 1'b1;
        end
        w_locks_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_locks <= '0;
            r_cnt   <= '0;
            r_blk   <= 1'b0;
        end else begin
            r_locks <= w_locks_nxt;
            if (w_inc && !mem_done_i) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (!w_inc && mem_done_i && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_accept && blocking_i) begin
                r_blk <= 1'b1;
            end else if (blk_done_i) begin
                r_blk <= 1'b0;
            end
        end
    end

    assign locks_o      = r_blk ? {{(NR-1){1'b1}}, 1'b0} : {r_locks[NR-1:1], 1'b0};
    assign mem_cnt_o    = r_cnt;
    assign mem_busy_o   = (r_cnt != '0);
    assign blk_active_o = r_blk;

endmodule

// File: tb/tb_reg_lock_tracker.sv
// Self-checking bench for reg_lock_tracker: directed scenarios plus a random soak
// against a behavioural model of locks, outstanding count and fence state.
module tb_reg_lock_tracker;

    localparam int unsigned NR        = 64;
    localparam int unsigned NWB       = 2;
    localparam int unsigned MEM_DEPTH = 4;
    localparam int unsigned RW        = $clog2(NR);
    localparam int unsigned CW        = $clog2(MEM_DEPTH + 1);

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              pl_valid_i;
    logic              blocking_i;
    logic [RW-1:0]     rd_i;
    logic [NR-1:0]     reg_req_i;
    logic              mem_op_i;
    logic              arb_gnt_i;
    logic [NWB-1:0]    wb_valid_i;
    logic [NWB*RW-1:0] wb_rd_i;
    logic              mem_done_i;
    logic              blk_done_i;
    logic              arb_req_o;
    logic [NR-1:0]     locks_o;
    logic [CW-1:0]     mem_cnt_o;
    logic              mem_busy_o;
    logic              blk_active_o;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    bit m_lock [NR];
    int m_cnt;
    bit m_blk;

    reg_lock_tracker #(.NR(NR), .NWB(NWB), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pl_valid_i   (pl_valid_i),
        .blocking_i   (blocking_i),
        .rd_i         (rd_i),
        .reg_req_i    (reg_req_i),
        .mem_op_i     (mem_op_i),
        .arb_gnt_i    (arb_gnt_i),
        .wb_valid_i   (wb_valid_i),
        .wb_rd_i      (wb_rd_i),
        .mem_done_i   (mem_done_i),
        .blk_done_i   (blk_done_i),
        .arb_req_o    (arb_req_o),
        .locks_o      (locks_o),
        .mem_cnt_o    (mem_cnt_o),
        .mem_busy_o   (mem_busy_o),
        .blk_active_o (blk_active_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit model_req();
        int nlocks = 0;
        for (int i = 1; i < int'(NR); i++) nlocks += m_lock[i];
        if (!pl_valid_i || m_blk) return 1'b0;
        for (int i = 0; i < int'(NR); i++) if (reg_req_i[i] && m_lock[i]) return 1'b0;
        if (int'(rd_i) != 0 && m_lock[int'(rd_i)]) return 1'b0;
        if (mem_op_i && m_cnt == int'(MEM_DEPTH)) return 1'b0;
        if (blocking_i && (nlocks != 0 || m_cnt != 0)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NR-1:0] model_locks();
        logic [NR-1:0] v = '0;
        for (int i = 1; i < int'(NR); i++) v[i] = m_blk ? 1'b1 : m_lock[i];
        return v;
    endfunction

    task automatic model_apply(input bit acc);
        bit inc;
        if (rst_i) begin
            for (int i = 0; i < int'(NR); i++) m_lock[i] = 1'b0;
            m_cnt = 0;
            m_blk = 1'b0;
            return;
        end
        for (int p = 0; p < int'(NWB); p++) begin
            if (wb_valid_i[p]) m_lock[int'(wb_rd_i[p*RW +: RW])] = 1'b0;
        end
        if (acc && int'(rd_i) != 0) m_lock[int'(rd_i)] = 1'b1;
        m_lock[0] = 1'b0;
        inc = acc && mem_op_i;
        if (inc && !mem_done_i) m_cnt++;
        else if (!inc && mem_done_i && m_cnt > 0) m_cnt--;
        if (acc && blocking_i) m_blk = 1'b1;
        else if (blk_done_i) m_blk = 1'b0;
    endtask

    task automatic drive(input bit v, input bit bk, input int rd, input logic [NR-1:0] req,
                         input bit mo, input bit gnt, input bit [NWB-1:0] wv,
                         input int w0, input int w1, input bit md, input bit bd, input bit rs);
        pl_valid_i = v;
        blocking_i = bk;
        rd_i       = RW'(rd);
        reg_req_i  = req;
        mem_op_i   = mo;
        arb_gnt_i  = gnt;
        wb_valid_i = wv;
        wb_rd_i    = {RW'(w1), RW'(w0)};
        mem_done_i = md;
        blk_done_i = bd;
        rst_i      = rs;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, 0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        bit acc;
        acc = arb_gnt_i && model_req();
        @(posedge clk_i);
        model_apply(acc);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 3, '0, 1, 1, 2'b11, 4, 5, 1, 1, 1);
        tick();
        idle();
        checks++;
        if (locks_o !== '0 || mem_cnt_o !== '0 || mem_busy_o !== 1'b0 || blk_active_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: locks=%h cnt=%0d busy=%b blk=%b expected all zero",
                     locks_o, mem_cnt_o, mem_busy_o, blk_active_o);
        end
    endtask

    task automatic test_lock_release();
        drive(1, 0, 5, '0, 0, 1, '0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, NR'(1) << 5, 0, 0, 2'b10, 0, 5, 0, 0, 0);
        checks++;
        if (locks_o !== (NR'(1) << 5)) begin
            errors++;
            $display("FAIL lock_set: locks=%h expected %h", locks_o, NR'(1) << 5);
        end
        checks++;
        if (arb_req_o !== 1'b0) begin
            errors++;
            $display("FAIL raw_block: arb_req=%b expected 0", arb_req_o);
        end
        tick();
        checks++;
        if (locks_o !== '0 || arb_req_o !== 1'b1) begin
            errors++;
            $display("FAIL wb_release: locks=%h arb_req=%b expected 0 and 1", locks_o, arb_req_o);
        end
    endtask

    task automatic test_waw();
        drive(1, 0, 7, '0, 0, 1, '0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 7, '0, 0, 0, '0, 0, 0, 0, 0, 0);
        checks++;
        if (arb_req_o !== 1'b0) begin
            errors++;
            $display("FAIL waw_block: arb_req=%b expected 0", arb_req_o);
        end
        drive(1, 0, 9, '0, 0, 1, 2'b11, 9, 7, 0, 0, 0);
        tick();
        idle();
        checks++;
        if (locks_o !== (NR'(1) << 9)) begin
            errors++;
            $display("FAIL set_wins: locks=%h expected %h", locks_o, NR'(1) << 9);
        end
        drive(0, 0, 0, '0, 0, 0, 2'b01, 9, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_mem_depth();
        for (int i = 0; i < int'(MEM_DEPTH); i++) begin
            drive(1, 0, 0, '0, 1, 1, '0, 0, 0, 0, 0, 0);
            tick();
        end
        drive(1, 0, 0, '0, 1, 0, '0, 0, 0, 0, 0, 0);
        checks++;
        if (mem_cnt_o !== CW'(MEM_DEPTH) || mem_busy_o !== 1'b1 || arb_req_o !== 1'b0) begin
            errors++;
            $display("FAIL mem_full: cnt=%0d busy=%b arb_req=%b expected %0d 1 0",
                     mem_cnt_o, mem_busy_o, arb_req_o, MEM_DEPTH);
        end
        drive(0, 0, 0, '0, 0, 0, '0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, '0, 1, 1, '0, 0, 0, 1, 0, 0);
        tick();
        idle();
        checks++;
        if (mem_cnt_o !== CW'(MEM_DEPTH - 1)) begin
            errors++;
            $display("FAIL acc_and_done: cnt=%0d expected %0d", mem_cnt_o, MEM_DEPTH - 1);
        end
        for (int i = 0; i < int'(MEM_DEPTH) + 1; i++) begin
            drive(0, 0, 0, '0, 0, 0, '0, 0, 0, 1, 0, 0);
            tick();
        end
        idle();
        checks++;
        if (mem_cnt_o !== '0 || mem_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL no_underflow: cnt=%0d busy=%b expected 0 0", mem_cnt_o, mem_busy_o);
        end
    endtask

    task automatic test_fence();
        logic [NR-1:0] all_but0;
        all_but0 = ~NR'(1);
        drive(1, 1, 0, '0, 0, 1, '0, 0, 0, 0, 0, 0);
        checks++;
        if (arb_req_o !== 1'b1) begin
            errors++;
            $display("FAIL fence_drained_req: arb_req=%b expected 1", arb_req_o);
        end
        tick();
        drive(1, 0, 3, '0, 0, 1, '0, 0, 0, 0, 0, 0);
        checks++;
        if (locks_o !== all_but0 || blk_active_o !== 1'b1 || arb_req_o !== 1'b0) begin
            errors++;
            $display("FAIL fence_active: locks=%h blk=%b arb_req=%b expected %h 1 0",
                     locks_o, blk_active_o, arb_req_o, all_but0);
        end
        tick();
        drive(0, 0, 0, '0, 0, 0, '0, 0, 0, 0, 1, 0);
        tick();
        idle();
        checks++;
        if (locks_o !== '0 || blk_active_o !== 1'b0) begin
            errors++;
            $display("FAIL fence_done: locks=%h blk=%b expected 0 0", locks_o, blk_active_o);
        end
        drive(1, 0, 0, '0, 1, 1, '0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, '0, 0, 1, '0, 0, 0, 0, 0, 0);
        checks++;
        if (arb_req_o !== 1'b0) begin
            errors++;
            $display("FAIL fence_wait_mem: arb_req=%b expected 0", arb_req_o);
        end
        tick();
        drive(0, 0, 0, '0, 0, 0, '0, 0, 0, 1, 0, 0);
        tick();
    endtask

    task automatic test_misuse();
        drive(0, 0, 4, '0, 0, 1, '0, 0, 0, 0, 0, 0);
        checks++;
        if (arb_req_o !== 1'b0) begin
            errors++;
            $display("FAIL invalid_req: arb_req=%b expected 0", arb_req_o);
        end
        tick();
        drive(1, 0, 0, '0, 0, 1, '0, 0, 0, 0, 0, 0);
        checks++;
        if (locks_o !== '0) begin
            errors++;
            $display("FAIL gnt_no_valid: locks=%h expected 0", locks_o);
        end
        tick();
        drive(1, 0, 4, '0, 0, 1, '0, 0, 0, 0, 0, 0);
        checks++;
        if (locks_o !== '0) begin
            errors++;
            $display("FAIL rd0_accept: locks=%h expected 0", locks_o);
        end
        tick();
        drive(1, 0, 6, NR'(1) << 4, 0, 1, '0, 0, 0, 0, 0, 0);
        tick();
        idle();
        checks++;
        if (locks_o !== (NR'(1) << 4)) begin
            errors++;
            $display("FAIL gnt_no_req: locks=%h expected %h", locks_o, NR'(1) << 4);
        end
        drive(0, 0, 0, '0, 0, 0, 2'b10, 0, 4, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 1, '0, 1, 1, '0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 2, '0, 1, 1, '0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 3, '0, 0, 1, '0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 10, '0, 1, 1, 2'b01, 1, 0, 1, 1, 1);
        tick();
        idle();
        checks++;
        if (locks_o !== '0 || mem_cnt_o !== '0 || blk_active_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ops: locks=%h cnt=%0d blk=%b expected all zero",
                     locks_o, mem_cnt_o, blk_active_o);
        end
        drive(1, 1, 0, '0, 0, 1, '0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 8, '0, 1, 1, 2'b11, 8, 9, 1, 0, 1);
        tick();
        idle();
        checks++;
        if (locks_o !== '0 || mem_cnt_o !== '0 || blk_active_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fence: locks=%h cnt=%0d blk=%b expected all zero",
                     locks_o, mem_cnt_o, blk_active_o);
        end
    endtask

    task automatic test_random();
        logic [NR-1:0] req;
        bit            exp_req;
        for (int c = 0; c < 20000; c++) begin
            req = '0;
            if ($urandom_range(0, 1) == 1) req[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 15)] = 1'b1;
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                  int'($urandom_range(0, 15)), req, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0, NWB'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 199) == 0);
            exp_req = model_req();
            checks++;
            if (arb_req_o !== exp_req) begin
                errors++;
                $display("FAIL rand_req cycle %0d: arb_req=%b expected %b", c, arb_req_o, exp_req);
            end
            tick();
            checks++;
            if (locks_o !== model_locks() || mem_cnt_o !== CW'(m_cnt)
                || mem_busy_o !== (m_cnt != 0) || blk_active_o !== m_blk) begin
                errors++;
                $display("FAIL rand_state cycle %0d: locks=%h cnt=%0d busy=%b blk=%b expected %h %0d %b %b",
                         c, locks_o, mem_cnt_o, mem_busy_o, blk_active_o,
                         model_locks(), m_cnt, m_cnt != 0, m_blk);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(NR); i++) m_lock[i] = 1'b0;
        m_cnt = 0;
        m_blk = 1'b0;
        idle();
        test_reset();
        test_lock_release();
        test_waw();
        test_mem_depth();
        test_fence();
        test_misuse();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
